// File: rtl/adder_32_if.sv
// Operand/result bundle for the registered adder/subtractor.
// The master drives operands and observes results; the slave is the adder.
interface adder_32_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             sub;
  logic [WIDTH-1:0] val_1;
  logic [WIDTH-1:0] val_2;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             out_valid;

  modport master (
    output in_valid, sub, val_1, val_2,
    input  out, carry, overflow, zero, out_valid
  );

  modport slave (
    input  in_valid, sub, val_1, val_2,
    output out, carry, overflow, zero, out_valid
  );
endinterface

// File: rtl/adder_32.sv
// Registered add/subtract with an explicit 4-bit-group carry-lookahead chain.
// Result and flags appear one clock after an accepted operand set.
module adder_32 #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  adder_32_if.slave  bus
);
  // WIDTH must be a multiple of 4 (minimum 4); groups never straddle a partial nibble.
  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   c;
  logic             grpG;
  logic             grpP;
  logic             cIn;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] out_d, out_q;
  logic             carry_d, carry_q;
  logic             overflow_d, overflow_q;
  logic             zero_d, zero_q;
  logic             valid_q;

  always_comb begin
    opB  = bus.sub ? ~bus.val_2 : bus.val_2;
    gen  = bus.val_1 & opB;
    prop = bus.val_1 ^ opB;
    c    = '0;
    c[0] = bus.sub;
    grpG = 1'b0;
    grpP = 1'b0;
    cIn  = 1'b0;
    // Lookahead inside each nibble; the group G/P terms ripple between nibbles.
    for (int j = 0; j < NG; j++) begin
      cIn  = c[4*j];
      c[4*j+1] = gen[4*j] | (prop[4*j] & cIn);
      c[4*j+2] = gen[4*j+1] | (prop[4*j+1] & gen[4*j])
               | (prop[4*j+1] & prop[4*j] & cIn);
      c[4*j+3] = gen[4*j+2] | (prop[4*j+2] & gen[4*j+1])
               | (prop[4*j+2] & prop[4*j+1] & gen[4*j])
               | (prop[4*j+2] & prop[4*j+1] & prop[4*j] & cIn);
      grpG = gen[4*j+3] | (prop[4*j+3] & gen[4*j+2])
           | (prop[4*j+3] & prop[4*j+2] & gen[4*j+1])
           | (prop[4*j+3] & prop[4*j+2] & prop[4*j+1] & gen[4*j]);
      grpP = prop[4*j+3] & prop[4*j+2] & prop[4*j+1] & prop[4*j];
      c[4*j+4] = grpG | (grpP & cIn);
    end
    sum = prop ^ c[WIDTH-1:0];
  end

  always_comb begin
    out_d      = sum;
    carry_d    = c[WIDTH];
    overflow_d = c[WIDTH] ^ c[WIDTH-1];
    zero_d     = (sum == '0);
  end

  // Idle cycles hold the last result, so X operands with in_valid low never reach the flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q      <= out_d;
        carry_q    <= carry_d;
        overflow_q <= overflow_d;
        zero_q     <= zero_d;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_adder_32.sv
// Directed vector table plus hand-written hold and reset sequences for adder_32.
module tb_adder_32;
  typedef struct {
    string       name;
    logic        subOp;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expOut;
    logic        expCarry;
    logic        expOvf;
    logic        expZero;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  vec_t vecs[14];

  adder_32_if #(.WIDTH(32)) bus ();

  adder_32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] eOut, input logic eCarry,
                             input logic eOvf, input logic eZero, input logic eValid);
    checkField({name, ".out"}, bus.out, eOut);
    checkField({name, ".carry"}, {31'b0, bus.carry}, {31'b0, eCarry});
    checkField({name, ".overflow"}, {31'b0, bus.overflow}, {31'b0, eOvf});
    checkField({name, ".zero"}, {31'b0, bus.zero}, {31'b0, eZero});
    checkField({name, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, eValid});
  endtask

  // Drive on the falling edge, then sample 1 ns after the next rising edge.
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                               input logic v);
    @(negedge clk);
    bus.sub      = s;
    bus.val_1    = a;
    bus.val_2    = b;
    bus.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"add5p9",    1'b0, 32'd5,        32'd9,        32'd14,       1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"add11p22",  1'b0, 32'h11,       32'h22,       32'h33,       1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"add0p0",    1'b0, 32'd0,        32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
    vecs[3]  = '{"addWrap",   1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b1};
    vecs[4]  = '{"addOvf",    1'b0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{"sub9m5",    1'b1, 32'd9,        32'd5,        32'd4,        1'b1, 1'b0, 1'b0};
    vecs[6]  = '{"sub5m9",    1'b1, 32'd5,        32'd9,        32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"subMinM1",  1'b1, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{"addMinMin", 1'b0, 32'h80000000, 32'h80000000, 32'd0,        1'b1, 1'b1, 1'b1};
    vecs[9]  = '{"sub7m7",    1'b1, 32'd7,        32'd7,        32'd0,        1'b1, 1'b0, 1'b1};
    vecs[10] = '{"addMixed",  1'b0, 32'h12345678, 32'h0FEDCBA9, 32'h22222221, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{"sub0m1",    1'b1, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{"subMaxMn1", 1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{"sub0m0",    1'b1, 32'd0,        32'd0,        32'd0,        1'b1, 1'b0, 1'b1};

    bus.in_valid = 1'b0;
    bus.sub      = 1'b0;
    bus.val_1    = '0;
    bus.val_2    = '0;

    // Asynchronous reset raised between edges must clear outputs immediately.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("resetAsync", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #100;
    checkOutput("resetHold", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("resetRelease", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].subOp, vecs[i].a, vecs[i].b, 1'b1);
      checkOutput(vecs[i].name, vecs[i].expOut, vecs[i].expCarry, vecs[i].expOvf,
                  vecs[i].expZero, 1'b1);
    end

    // Hold behaviour: idle cycles keep the last result, even with X operands.
    applyStimulus(1'b0, 32'd100, 32'd23, 1'b1);
    checkOutput("hold.load", 32'd123, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd5, 32'd5, 1'b0);
    checkOutput("hold.idle", 32'd123, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'bx, 32'hxxxxxxxx, 32'hxxxxxxxx, 1'b0);
    checkOutput("hold.xIdle", 32'd123, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd1, 32'd2, 1'b1);
    checkOutput("b2b.first", 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd10, 32'd20, 1'b1);
    checkOutput("b2b.second", 32'd30, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0);
    checkOutput("b2b.idle", 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-stream reset discards the live result and nothing reappears until a new in_valid.
    applyStimulus(1'b0, 32'h7FFFFFFF, 32'd1, 1'b1);
    checkOutput("midRst.load", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRst.clear", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.val_1    = 32'd3;
    bus.val_2    = 32'd4;
    @(posedge clk);
    #1;
    checkOutput("midRst.after1", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("midRst.after2", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd3, 32'd4, 1'b1);
    checkOutput("midRst.resume", 32'd7, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/adder_32.md
Name: adder_32

Overview:
- Registered two-operand integer adder/subtractor for the single-cycle RISC-V datapath (PC increment, branch-target and address arithmetic).
- Sums val_1 and val_2, or subtracts val_2 from val_1 when sub is set.
- Produces a WIDTH-bit result plus carry, signed-overflow and zero flags, one clock after inputs are accepted.
- Carry chain is an explicit 4-bit-group carry-lookahead network, not a behavioural "+".

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4, minimum 4.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, operands on val_1/val_2/sub are valid this cycle.
- sub, input, 1, 0 = val_1 + val_2; 1 = val_1 - val_2.
- val_1, input, WIDTH, first operand.
- val_2, input, WIDTH, second operand.
- out, output, WIDTH, registered result, modulo 2^WIDTH.
- carry, output, 1, registered carry out of the MSB. For sub, 1 means no borrow.
- overflow, output, 1, registered two's-complement signed overflow.
- zero, output, 1, registered flag: out == 0.
- out_valid, output, 1, out and flags hold a new result this cycle.

Behaviour:
- One clock; all outputs come from flops on the clk rising edge.
- Reset:
  - rst is asynchronous and active-high.
  - While rst = 1: out = 0, carry = 0, overflow = 0, zero = 1, out_valid = 0.
  - Release is synchronous to the next clk edge.
  - Reset asserted mid-operation discards any in-flight result; no output update occurs until an in_valid after release.
- Operand conditioning:
  - b = sub ? ~val_2 : val_2; carry-in c0 = sub.
  - The sum is computed over val_1, b and c0.
- Carry network:
  - Per bit: generate g = a&b, propagate p = a^b.
  - Per 4-bit group: group G/P and internal carries computed by lookahead equations.
  - Between groups: carries ripple through the group G/P terms.
  - sum[i] = p[i] ^ c[i].
- Flags:
  - carry = c[WIDTH].
  - overflow = c[WIDTH] ^ c[WIDTH-1].
  - zero = (sum == 0).
- Latency and handshake:
  - Latency is exactly 1 cycle. If in_valid = 1 at edge k, then out, flags and out_valid = 1 are presented after edge k.
  - If in_valid = 0 at an edge: out_valid goes 0, and out and the flags hold their previous values.
  - No back-pressure; a new operation can be accepted every cycle.
- Arithmetic is modulo 2^WIDTH; wrap-around is not an error and is indicated only by the flags.
- Inputs must be stable only around the clk edge; the combinational path is not observable at the outputs.
- X on inputs with in_valid = 0 must not disturb the held outputs.

Test Plan:
- Reset: assert rst asynchronously between edges -> out = 0, zero = 1, carry = 0, overflow = 0, out_valid = 0 immediately; hold 100 ns with val_1 = val_2 = 0.
- Add after reset: in_valid = 1, sub = 0, val_1 = 5, val_2 = 9 -> next edge out = 14, zero = 0, carry = 0, overflow = 0, out_valid = 1. Then val_1 = 0x11, val_2 = 0x22 -> out = 0x33. Then 0 + 0 -> out = 0, zero = 1.
- Wrap and flags:
  - 0xFFFFFFFF + 1 -> out = 0, carry = 1, zero = 1, overflow = 0.
  - 0x7FFFFFFF + 1 -> out = 0x80000000, overflow = 1, carry = 0.
- Subtract:
  - sub = 1, 9 - 5 -> out = 4, carry = 1.
  - 5 - 9 -> out = 0xFFFFFFFC, carry = 0.
  - 0x80000000 - 1 -> out = 0x7FFFFFFF, overflow = 1.
- Hold and back-to-back: alternate in_valid 1/0 with changing operands -> out_valid tracks in_valid delayed by one cycle; out holds during in_valid = 0. Continuous in_valid = 1 updates every cycle.
- Mid-stream reset: pulse rst while out_valid = 1 -> outputs clear at once. After release with in_valid = 0, out_valid stays 0 and out stays 0.
